frame_slice_renderer: RTL
=========================

Name: frame_slice_renderer

Overview:
Parametrised column-sweep renderer that replaces the fixed-size, single-colour frame drawer in front of vga_adapter. Each frame_tick rising edge starts a frame. The block then requests one wall slice (height, colour) per screen column from the ray engine over a valid/ready handshake. For each column it emits one pixel per clock as X/Y/color_out/draw_enable: ceiling colour above the slice, slice colour inside it, floor colour below it.

Parameters:
SCREEN_W, 160, columns per frame
SCREEN_H, 120, rows per column
X_BITS, 8, width of X and col_x
Y_BITS, 7, width of Y
COLOUR_BITS, 3, width of colours
CEIL_COLOUR, 3'b001, colour for rows above slice
FLOOR_COLOUR, 3'b010, colour for rows below slice

Ports:
clock50MHz  in  1  system clock
resetn  in  1  asynchronous active-low reset
frame_tick  in  1  slow 60 Hz clock from rate_divider; rising edge requests a frame
slice_valid  in  1  ray engine has slice for col_x
slice_ready  out  1  renderer accepts slice this cycle
slice_height  in  Y_BITS+1  wall height in pixels (may exceed SCREEN_H)
slice_colour  in  COLOUR_BITS  wall colour
col_x  out  X_BITS  column whose slice is expected
X  out  X_BITS  pixel x to vga_adapter
Y  out  Y_BITS  pixel y to vga_adapter
color_out  out  COLOUR_BITS  pixel colour
draw_enable  out  1  plot strobe
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after last pixel
frame_overrun  out  1  one-cycle pulse when tick arrives while busy

Behaviour:
- Reset (async, resetn=0): state IDLE. All outputs 0, col_x=0, sync/edge registers 0.
- frame_tick: 2-flop synchroniser, then edge detect (start = sync & ~prev).
- Tick high at reset release gives a start 3 cycles after release. This is defined behaviour.
- IDLE: busy=0, slice_ready=0. On start: col_x=0, busy=1, go to WAIT_SLICE.
- WAIT_SLICE: slice_ready=1, draw_enable=0.
  - On slice_valid & slice_ready, latch h_eff = min(slice_height, SCREEN_H).
  - top = (SCREEN_H - h_eff) >> 1 (floor); bottom = top + h_eff (exclusive).
  - Latch colour, set y=0, go to DRAW.
- DRAW: slice_ready=0. Registered outputs each cycle:
  - draw_enable=1, X=col_x, Y=y.
  - color_out = y<top ? CEIL_COLOUR : (y<bottom ? latched colour : FLOOR_COLOUR).
  - y increments each cycle.
  - After y=SCREEN_H-1: if col_x=SCREEN_W-1 go to DONE, else col_x+1 and go to WAIT_SLICE.
- DONE: frame_done=1 for one cycle, busy=0, go to IDLE with col_x=0.
- Latency: the first pixel of a column appears on the cycle after the handshake.
- Minimum frame time is SCREEN_W*(SCREEN_H+1) cycles (19360 at defaults), well inside one 60 Hz period.
- slice_valid low stalls in WAIT_SLICE indefinitely. Outputs hold, draw_enable=0.
- start while busy or in DONE: ignored; frame_overrun pulses 1 cycle; the current frame is unaffected.
- h_eff=0: top=bottom=SCREEN_H/2; the column is ceiling then floor.
- h ≥ SCREEN_H: whole column is slice colour.
- Arithmetic is done in Y_BITS+1 bits to avoid wrap. col_x and y never wrap mid-frame.
- Reset mid-frame: immediate return to IDLE. No draw_enable until a new tick edge.

Decomposition:
- Package frame_render_pkg holds:
  - state encoding (IDLE, WAIT_SLICE, DRAW, DONE);
  - default SCREEN_W/SCREEN_H;
  - default CEIL/FLOOR colour constants.
- One sub-module, tick_edge_sync: the 2-flop synchroniser plus rising-edge detector, with async active-low reset.

Test Plan:
- Reset, then frame_tick 0→1 → busy=1 and slice_ready=1 within 3 cycles, col_x=0, no draw_enable.
- Slice h=50, colour 3'b100 at col 0 → 120 consecutive draw_enable cycles with X=0, Y=0..119:
  - color_out 3'b001 for Y 0–34;
  - 3'b100 for Y 35–84;
  - 3'b010 for Y 85–119.
- h=0 → Y 0–59 ceiling, Y 60–119 floor. h=200 → all 120 pixels slice colour.
- slice_valid held high for a full frame → exactly 19200 draw_enable pulses; frame_done once, 1 cycle after X=159/Y=119; 19360 cycles from first handshake.
- Second tick edge mid-frame → frame_overrun single pulse; pixel stream identical to an undisturbed frame.
- resetn low during DRAW at col 37 → all outputs 0 immediately; no draw_enable until a new tick edge; next frame restarts at col_x=0.

Source files
------------

// File: rtl/frame_render_pkg.sv
// rtl/frame_render_pkg.sv - shared state encoding and default geometry/colours for the frame renderer
package frame_render_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SLICE = 2'd1,
        DRAW       = 2'd2,
        DONE       = 2'd3
    } render_state_t;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    localparam logic [2:0] DEF_CEIL_COLOUR  = 3'b001;
    localparam logic [2:0] DEF_FLOOR_COLOUR = 3'b010;

endpackage

// File: rtl/tick_edge_sync.sv
// rtl/tick_edge_sync.sv - two-flop synchroniser plus rising-edge detector for the frame tick
module tick_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_in,
    output logic start
);

    logic sync1;
    logic sync2;
    logic prev;

    // Bring the slow tick into the clock domain and keep one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= tick_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign start = sync2 & ~prev;

endmodule

// File: rtl/frame_slice_renderer.sv
// rtl/frame_slice_renderer.sv - column-sweep renderer: one wall slice per column, one pixel per clock
module frame_slice_renderer
    import frame_render_pkg::*;
#(
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int COLOUR_BITS = 3,
    parameter logic [COLOUR_BITS-1:0] CEIL_COLOUR  = COLOUR_BITS'(DEF_CEIL_COLOUR),
    parameter logic [COLOUR_BITS-1:0] FLOOR_COLOUR = COLOUR_BITS'(DEF_FLOOR_COLOUR)
) (
    input  logic                   clock50MHz,
    input  logic                   resetn,
    input  logic                   frame_tick,
    input  logic                   slice_valid,
    output logic                   slice_ready,
    input  logic [Y_BITS:0]        slice_height,
    input  logic [COLOUR_BITS-1:0] slice_colour,
    output logic [X_BITS-1:0]      col_x,
    output logic [X_BITS-1:0]      X,
    output logic [Y_BITS-1:0]      Y,
    output logic [COLOUR_BITS-1:0] color_out,
    output logic                   draw_enable,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_overrun
);

    // One extra bit on all row arithmetic so top/bottom and y never wrap
    localparam int                YW     = Y_BITS + 1;
    localparam logic [YW-1:0]     H_LIM  = YW'(SCREEN_H);
    localparam logic [YW-1:0]     Y_LAST = YW'(SCREEN_H - 1);
    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(SCREEN_W - 1);

    logic start;

    render_state_t state, state_n;
    logic [X_BITS-1:0]      col_q, col_n;
    logic [YW-1:0]          y_q, y_n;
    logic [YW-1:0]          top_q, top_n;
    logic [YW-1:0]          bot_q, bot_n;
    logic [COLOUR_BITS-1:0] wall_q, wall_n;

    logic [X_BITS-1:0]      x_out_n;
    logic [Y_BITS-1:0]      y_out_n;
    logic [COLOUR_BITS-1:0] colour_n;
    logic                   draw_n;
    logic                   done_n;
    logic                   overrun_n;

    logic [YW-1:0]          h_eff;
    logic [YW-1:0]          top_calc;
    logic [YW-1:0]          bot_calc;
    logic [COLOUR_BITS-1:0] pix_colour;

    tick_edge_sync u_tick_sync (
        .clk     (clock50MHz),
        .rst_n   (resetn),
        .tick_in (frame_tick),
        .start   (start)
    );

    // Slice geometry: clamp height to the screen and centre it vertically
    always_comb begin
        h_eff    = (slice_height > H_LIM) ? H_LIM : slice_height;
        top_calc = (H_LIM - h_eff) >> 1;
        bot_calc = top_calc + h_eff;
    end

    // Colour of the current row: ceiling, wall band, then floor
    always_comb begin
        pix_colour = FLOOR_COLOUR;
        if (y_q < top_q) begin
            pix_colour = CEIL_COLOUR;
        end else if (y_q < bot_q) begin
            pix_colour = wall_q;
        end
    end

    // Next-state and next-output logic; pixel outputs hold their last value outside DRAW
    always_comb begin
        state_n   = state;
        col_n     = col_q;
        y_n       = y_q;
        top_n     = top_q;
        bot_n     = bot_q;
        wall_n    = wall_q;
        x_out_n   = X;
        y_out_n   = Y;
        colour_n  = color_out;
        draw_n    = 1'b0;
        done_n    = 1'b0;
        overrun_n = start && (state != IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    col_n   = '0;
                    state_n = WAIT_SLICE;
                end
            end
            WAIT_SLICE: begin
                if (slice_valid) begin
                    top_n   = top_calc;
                    bot_n   = bot_calc;
                    wall_n  = slice_colour;
                    y_n     = '0;
                    state_n = DRAW;
                end
            end
            DRAW: begin
                draw_n   = 1'b1;
                x_out_n  = col_q;
                y_out_n  = y_q[Y_BITS-1:0];
                colour_n = pix_colour;
                y_n      = y_q + YW'(1);
                if (y_q == Y_LAST) begin
                    if (col_q == X_LAST) begin
                        state_n = DONE;
                    end else begin
                        col_n   = col_q + X_BITS'(1);
                        state_n = WAIT_SLICE;
                    end
                end
            end
            DONE: begin
                done_n  = 1'b1;
                col_n   = '0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, datapath and registered pixel outputs; reset drops everything straight to idle
    always_ff @(posedge clock50MHz or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            col_q         <= '0;
            y_q           <= '0;
            top_q         <= '0;
            bot_q         <= '0;
            wall_q        <= '0;
            X             <= '0;
            Y             <= '0;
            color_out     <= '0;
            draw_enable   <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            state         <= state_n;
            col_q         <= col_n;
            y_q           <= y_n;
            top_q         <= top_n;
            bot_q         <= bot_n;
            wall_q        <= wall_n;
            X             <= x_out_n;
            Y             <= y_out_n;
            color_out     <= colour_n;
            draw_enable   <= draw_n;
            frame_done    <= done_n;
            frame_overrun <= overrun_n;
        end
    end

    assign slice_ready = (state == WAIT_SLICE);
    assign busy        = (state == WAIT_SLICE) || (state == DRAW);
    assign col_x       = col_q;

endmodule
